mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit between the EX/MEM and MEM/WB pipeline registers. It takes the ALU address, store data and width from EX/MEM and runs one request/acknowledge transaction per access on the data-memory port. Loads are aligned and sign- or zero-extended into `mem_rdata`. The unit stalls the upstream pipeline until the access completes, and gates `regwrite` so MEM/WB never captures a partial result.

## Interface
- `XLEN`, 32: datapath and address width.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_in`  in  1  EX/MEM holds a live instruction.
- `memread_in`  in  1  load.
- `memwrite_in`  in  1  store; wins if both set.
- `regwrite_in`  in  1  EX/MEM regwrite.
- `funct3_in`  in  3  width: 000 byte, 001 half, 010 word; bit2 = unsigned (loads); funct3[1:0]=11 treated as word.
- `addr_in`  in  XLEN  ALU result (byte address).
- `wdata_in`  in  XLEN  rs2 store data.
- `dm_req`  out  1  request valid, registered.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  XLEN  word address, [1:0] forced 0.
- `dm_wstrb`  out  4  byte-lane enables (writes).
- `dm_wdata`  out  XLEN  lane-replicated store data.
- `dm_ack`  in  1  memory done; read data valid same cycle.
- `dm_rdata`  in  XLEN  raw read word.
- `mem_rdata`  out  XLEN  aligned/extended load data to MEM/WB.
- `regwrite_out`  out  1  qualified regwrite to MEM/WB.
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- `misalign`  out  1  one-cycle misaligned-access flag.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE with no access: pass-through; `stall`=0, `mem_rdata`=0, `regwrite_out`=`regwrite_in`.
- IDLE, access, aligned:
  - `stall`=1 and `regwrite_out`=0 combinationally.
  - At the edge, register the `dm_*` fields, set `dm_req`=1, and go to BUSY.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0):
  - No request is issued.
  - `misalign`=1, `stall`=0, `regwrite_out`=0, `mem_rdata`=0 for that cycle; the instruction retires as a bubble.
- BUSY: `stall`=1, `regwrite_out`=0, all `dm_*` held stable.
  - On `dm_ack`=1: capture the aligned load data (0 for stores), clear `dm_req`/`dm_we`/`dm_wstrb`, go to DONE.
- DONE: `stall`=0, `mem_rdata`=captured data, `regwrite_out`=`regwrite_in`; next state IDLE.
- Store lanes:
  - SB: `wstrb`=0001<<addr[1:0], `wdata`={4{b}}.
  - SH: `wstrb`=addr[1]?1100:0011, `wdata`={2{h}}.
  - SW: `wstrb`=1111.
- Loads: lane = `dm_rdata`>>(8·addr[1:0]); byte/half sign-extended when funct3[2]=0, zero-extended when 1.

## Timing
- Reset:
  - `dm_req`, `dm_we`, `dm_wstrb`, `dm_addr`, `dm_wdata`, `mem_rdata` = 0; state IDLE.
  - `stall`, `regwrite_out`, `misalign` forced 0 while `rst`=1.
- Latency: access cycle + N BUSY cycles (N ≥ 1, ends on the ack cycle) + 1 DONE cycle. Minimum 3 cycles with ack on the first BUSY cycle.
- EX/MEM advances on the DONE edge; the next instruction is evaluated in IDLE the following cycle. Back-to-back accesses therefore never overlap.
- `dm_ack` outside BUSY is ignored.
- Reset mid-BUSY: `dm_req` drops immediately; a late ack is ignored.

## Structure
- Shared package `cpu_pkg`:
  - funct3 width constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - 2-bit state encoding `MAU_IDLE`/`MAU_BUSY`/`MAU_DONE`.
- One combinational sub-module, `load_align` (raw word, addr[1:0], funct3 → extended data), reused by formal and unit tests.

## Test plan
- LB at addr 0x103, memory word 0x80FF_1234, ack after 1 cycle → `stall` high 2 cycles; DONE `mem_rdata`=0xFFFF_FF80, `regwrite_out`=1.
- LHU at 0x202, word 0x8001_7FFF, ack after 4 cycles → `dm_req` held 4 cycles with `dm_addr`=0x200 stable; `mem_rdata`=0x0000_8001.
- SB of 0x0000_00AB at 0x301 → `dm_we`=1, `dm_wstrb`=0010, `dm_wdata`=0xABAB_ABAB, `regwrite_out`=0 throughout.
- LW at 0x402 → `misalign`=1 for one cycle, `dm_req` never asserts, `stall`=0, `regwrite_out`=0.
- Non-memory ADD (`regwrite_in`=1) → `stall`=0, `regwrite_out`=1 same cycle, `mem_rdata`=0.
- `rst` asserted in BUSY, ack arrives 1 cycle after release → `dm_req`=0 asynchronously, state IDLE, ack ignored, all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store width codes and
// memory-access unit state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_BUSY = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_e;

  // Byte-lane enables for a store of the given width.
  function automatic logic [3:0] store_strb(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] s;
    unique case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the addressed byte/half of a raw memory word down
// to bit 0 and sign- or zero-extends it.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;
  logic            sx;

  assign sh = raw >> {off, 3'b000};
  assign sx = ~funct3[2];

  always_comb begin
    data = sh;
    unique case (funct3[1:0])
      2'b00:
        data = {{(XLEN-8){sx & sh[7]}}, sh[7:0]};
      2'b01:
        data = {{(XLEN-16){sx & sh[15]}}, sh[15:0]};
      default:
        data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/ack transaction per
// access, stalls upstream until done, gates regwrite.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            memread_in,
  input  logic            memwrite_in,
  input  logic            regwrite_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] wdata_in,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [3:0]      dm_wstrb,
  output logic [XLEN-1:0] dm_wdata,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic [XLEN-1:0] mem_rdata,
  output logic            regwrite_out,
  output logic            stall,
  output logic            misalign
);

  mau_state_e state_q, state_d;

  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      strb_q, strb_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;

  logic            access;
  logic            is_h;
  logic            is_w;
  logic            mis_c;
  logic            start;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] aligned;

  assign access = valid_in & (memread_in | memwrite_in);
  assign is_h   = funct3_in[1:0] == 2'b01;
  assign is_w   = funct3_in[1];
  assign mis_c  = (is_h & addr_in[0])
                | (is_w & (|addr_in[1:0]));
  assign start  = (state_q == MAU_IDLE)
                & access & ~mis_c;

  always_comb begin
    unique case (funct3_in[1:0])
      2'b00:   lane_wdata = {4{wdata_in[7:0]}};
      2'b01:   lane_wdata = {2{wdata_in[15:0]}};
      default: lane_wdata = wdata_in;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_align (
    .raw    (dm_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MAU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MAU_IDLE: if (start)  state_d = MAU_BUSY;
      MAU_BUSY: if (dm_ack) state_d = MAU_DONE;
      MAU_DONE:             state_d = MAU_IDLE;
      default:              state_d = MAU_IDLE;
    endcase
  end

  // Request fields latch on start and stay frozen through BUSY.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    if (start) begin
      req_d   = 1'b1;
      we_d    = memwrite_in;
      addr_d  = {addr_in[XLEN-1:2], 2'b00};
      strb_d  = memwrite_in
              ? store_strb(funct3_in, addr_in[1:0])
              : 4'b0000;
      wdata_d = lane_wdata;
      off_d   = addr_in[1:0];
      f3_d    = funct3_in;
    end else if (state_q == MAU_BUSY && dm_ack) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      strb_d  = 4'b0000;
      rdata_d = we_q ? '0 : aligned;
    end
  end

  always_comb begin
    stall        = 1'b0;
    regwrite_out = 1'b0;
    misalign     = 1'b0;
    mem_rdata    = '0;
    if (!rst) begin
      unique case (state_q)
        MAU_IDLE: begin
          if (access && mis_c) begin
            misalign = 1'b1;
          end else if (access) begin
            stall = 1'b1;
          end else begin
            regwrite_out = regwrite_in;
          end
        end
        MAU_BUSY: stall = 1'b1;
        MAU_DONE: begin
          mem_rdata    = rdata_q;
          regwrite_out = regwrite_in;
        end
        default: ;
      endcase
    end
  end

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wstrb = strb_q;
  assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed
// expected values.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, memread_in, memwrite_in;
  logic        regwrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] mem_rdata;
  logic        regwrite_out, stall, misalign;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .memread_in   (memread_in),
    .memwrite_in  (memwrite_in),
    .regwrite_in  (regwrite_in),
    .funct3_in    (funct3_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wstrb     (dm_wstrb),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .mem_rdata    (mem_rdata),
    .regwrite_out (regwrite_out),
    .stall        (stall),
    .misalign     (misalign)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  task automatic idle_inputs();
    valid_in    = 1'b0;
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    regwrite_in = 1'b0;
    funct3_in   = F3_W;
    addr_in     = '0;
    wdata_in    = '0;
  endtask

  // Drives one access from IDLE through DONE; n = BUSY cycles.
  task automatic do_access(
    input string       tag,
    input logic        rd,
    input logic        wr,
    input logic        rw,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rword,
    input int          n,
    input logic [31:0] exp_rd,
    input logic [3:0]  exp_strb,
    input logic [31:0] exp_wd
  );
    valid_in    = 1'b1;
    memread_in  = rd;
    memwrite_in = wr;
    regwrite_in = rw;
    funct3_in   = f3;
    addr_in     = a;
    wdata_in    = wd;
    @(negedge clk);
    chk({tag, ".acc_stall"}, 32'(stall), 32'd1);
    chk({tag, ".acc_rw"}, 32'(regwrite_out), 32'd0);
    chk({tag, ".acc_req"}, 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= n; k++) begin
      dm_ack   = (k == n);
      dm_rdata = rword;
      @(negedge clk);
      chk({tag, ".req"}, 32'(dm_req), 32'd1);
      chk({tag, ".addr"}, dm_addr, a & 32'hFFFF_FFFC);
      chk({tag, ".we"}, 32'(dm_we), 32'(wr));
      chk({tag, ".strb"}, 32'(dm_wstrb), 32'(exp_strb));
      if (wr) chk({tag, ".wdata"}, dm_wdata, exp_wd);
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".busy_rw"}, 32'(regwrite_out), 32'd0);
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    @(negedge clk);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".rdata"}, mem_rdata, exp_rd);
    chk({tag, ".done_rw"}, 32'(regwrite_out), 32'(rw));
    chk({tag, ".done_req"}, 32'(dm_req), 32'd0);
    chk({tag, ".done_we"}, 32'(dm_we), 32'd0);
    chk({tag, ".done_strb"}, 32'(dm_wstrb), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    dm_ack   = 1'b0;
    dm_rdata = '0;
    rst      = 1'b1;
    // Live access inputs during reset must not leak out.
    valid_in    = 1'b1;
    memread_in  = 1'b1;
    memwrite_in = 1'b0;
    regwrite_in = 1'b1;
    funct3_in   = F3_W;
    addr_in     = 32'h0000_0404;
    wdata_in    = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    chk("rst.req", 32'(dm_req), 32'd0);
    chk("rst.we", 32'(dm_we), 32'd0);
    chk("rst.strb", 32'(dm_wstrb), 32'd0);
    chk("rst.addr", dm_addr, 32'd0);
    chk("rst.wdata", dm_wdata, 32'd0);
    chk("rst.rdata", mem_rdata, 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.rw", 32'(regwrite_out), 32'd0);
    chk("rst.mis", 32'(misalign), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;

    // Non-memory ADD passes straight through.
    valid_in    = 1'b1;
    regwrite_in = 1'b1;
    @(negedge clk);
    chk("add.stall", 32'(stall), 32'd0);
    chk("add.rw", 32'(regwrite_out), 32'd1);
    chk("add.rdata", mem_rdata, 32'd0);
    chk("add.req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    do_access("lb", 1, 0, 1, F3_B, 32'h0000_0103, '0,
              32'h80FF_1234, 1, 32'hFFFF_FF80,
              4'b0000, '0);
    do_access("lhu", 1, 0, 1, F3_HU, 32'h0000_0202, '0,
              32'h8001_7FFF, 4, 32'h0000_8001,
              4'b0000, '0);
    do_access("lh", 1, 0, 1, F3_H, 32'h0000_0200, '0,
              32'h0000_8001, 2, 32'hFFFF_8001,
              4'b0000, '0);
    do_access("lbu", 1, 0, 1, F3_BU, 32'h0000_0101, '0,
              32'h0000_F200, 1, 32'h0000_00F2,
              4'b0000, '0);
    do_access("lw", 1, 0, 1, F3_W, 32'h0000_0408, '0,
              32'hDEAD_BEEF, 3, 32'hDEAD_BEEF,
              4'b0000, '0);
    do_access("sb", 0, 1, 0, F3_B, 32'h0000_0301,
              32'h0000_00AB, 32'h5555_5555, 2, 32'd0,
              4'b0010, 32'hABAB_ABAB);
    do_access("sh", 0, 1, 0, F3_H, 32'h0000_0302,
              32'h1234_5678, 32'h0, 1, 32'd0,
              4'b1100, 32'h5678_5678);
    do_access("sw", 0, 1, 0, F3_W, 32'h0000_0310,
              32'hCAFE_F00D, 32'h0, 1, 32'd0,
              4'b1111, 32'hCAFE_F00D);

    // Misaligned word load retires as a bubble.
    valid_in    = 1'b1;
    memread_in  = 1'b1;
    regwrite_in = 1'b1;
    funct3_in   = F3_W;
    addr_in     = 32'h0000_0402;
    @(negedge clk);
    chk("mis.flag", 32'(misalign), 32'd1);
    chk("mis.stall", 32'(stall), 32'd0);
    chk("mis.rw", 32'(regwrite_out), 32'd0);
    chk("mis.rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("mis.req", 32'(dm_req), 32'd0);
    chk("mis.flag_clr", 32'(misalign), 32'd0);

    // Reset in BUSY; the late ack must be ignored.
    @(posedge clk); #1;
    valid_in    = 1'b1;
    memread_in  = 1'b1;
    regwrite_in = 1'b1;
    funct3_in   = F3_W;
    addr_in     = 32'h0000_0500;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rbusy.req", 32'(dm_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rbusy.req_drop", 32'(dm_req), 32'd0);
    chk("rbusy.stall", 32'(stall), 32'd0);
    chk("rbusy.addr", dm_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dm_ack   = 1'b1;
    dm_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rbusy.ack_req", 32'(dm_req), 32'd0);
    chk("rbusy.ack_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    chk("rbusy.post_rdata", mem_rdata, 32'd0);
    chk("rbusy.post_rw", 32'(regwrite_out), 32'd0);
    @(posedge clk); #1;
    // Unit must be back in IDLE and accept a new access.
    do_access("post", 1, 0, 1, F3_BU, 32'h0000_0103, '0,
              32'h80FF_1234, 1, 32'h0000_0080,
              4'b0000, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
